// File: rtl/approx_err_monitor.sv
// Error-metric monitor for a registered 16-bit approximate adder.
// Compares the adder SUM against an exact reference over a window of WIN samples.
module approx_err_monitor #(
    parameter int WIN   = 1024,
    parameter int CNT_W = 11,
    parameter int SED_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic [15:0]      a_i,
    input  logic [15:0]      b_i,
    input  logic [16:0]      approx_sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [SED_W-1:0] sed_o,
    output logic [16:0]      max_ed_o,
    output logic [CNT_W-1:0] sample_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] issued_q;
    logic             v1_q, v2_q, done_q;
    logic [16:0]      exact_q, ed_q, max_ed_q;
    logic [CNT_W-1:0] err_cnt_q, sample_cnt_q;
    logic [SED_W-1:0] sed_q;

    logic             accept;
    logic [16:0]      ed_d;
    logic [SED_W:0]   sedSum;
    logic [SED_W-1:0] sed_d;

    always_comb begin
        accept = in_valid_i && (state_q == RUN) && (issued_q < WIN_C);
        if (exact_q >= approx_sum_i) ed_d = exact_q - approx_sum_i;
        else                         ed_d = approx_sum_i - exact_q;
        // One extra carry bit detects overflow so SED clamps instead of wrapping.
        sedSum = {1'b0, sed_q} + {{(SED_W-16){1'b0}}, ed_q};
        sed_d  = sedSum[SED_W] ? '1 : sedSum[SED_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            done_q       <= 1'b0;
            exact_q      <= '0;
            ed_q         <= '0;
            max_ed_q     <= '0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
            sed_q        <= '0;
        end else begin
            done_q <= 1'b0;

            v1_q <= accept;
            if (accept) begin
                exact_q  <= {1'b0, a_i} + {1'b0, b_i};
                issued_q <= issued_q + 1'b1;
            end

            v2_q <= v1_q;
            if (v1_q) ed_q <= ed_d;

            if (v2_q) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
                if (ed_q != 17'd0) err_cnt_q <= err_cnt_q + 1'b1;
                sed_q <= sed_d;
                if (ed_q > max_ed_q) max_ed_q <= ed_q;
            end

            // Completion waits for the last in-flight sample to reach the accumulator.
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q      <= RUN;
                        issued_q     <= '0;
                        v1_q         <= 1'b0;
                        v2_q         <= 1'b0;
                        max_ed_q     <= '0;
                        err_cnt_q    <= '0;
                        sample_cnt_q <= '0;
                        sed_q        <= '0;
                    end
                end
                RUN: begin
                    if (v2_q && (sample_cnt_q == LAST_C)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;
    assign err_cnt_o    = err_cnt_q;
    assign sed_o        = sed_q;
    assign max_ed_o     = max_ed_q;
    assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed self-checking bench for approx_err_monitor (WIN=4, SED_W=18).
// The approximate adder is modelled as a register delaying the chosen SUM by one cycle.
module tb_approx_err_monitor;

    localparam int WIN   = 4;
    localparam int CNT_W = 4;
    localparam int SED_W = 18;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             inValid = 1'b0;
    logic [15:0]      a = '0;
    logic [15:0]      b = '0;
    logic [16:0]      approxIn = '0;
    logic [16:0]      approxSum = '0;
    logic             busy, done;
    logic [CNT_W-1:0] errCnt, sampleCnt;
    logic [SED_W-1:0] sed;
    logic [16:0]      maxEd;

    int checks = 0;
    int failures = 0;
    int edges;
    int doneSeen;

    approx_err_monitor #(.WIN(WIN), .CNT_W(CNT_W), .SED_W(SED_W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(inValid),
        .a_i(a), .b_i(b), .approx_sum_i(approxSum),
        .busy_o(busy), .done_o(done), .err_cnt_o(errCnt), .sed_o(sed),
        .max_ed_o(maxEd), .sample_cnt_o(sampleCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) approxSum <= approxIn;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic [16:0] apx, input logic vld);
        a = av; b = bv; approxIn = apx; inValid = vld;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int count);
        int n;
        n = 0;
        count = -1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                count = n;
                break;
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstSed", sed, 0);
        checkOutput("rstSample", sampleCnt, 0);
        rst = 1'b0;

        $display("[TB] exact stream");
        pulseStart();
        checkOutput("t1Busy", busy, 1);
        for (int i = 0; i < 4; i++) applyStimulus(16'h1234, 16'h0F0F, 17'h02143, 1'b1);
        waitDone(edges);
        checkOutput("t1DoneLat", edges, 2);
        checkOutput("t1Err", errCnt, 0);
        checkOutput("t1Sed", sed, 0);
        checkOutput("t1Max", maxEd, 0);
        checkOutput("t1Sample", sampleCnt, 4);
        checkOutput("t1BusyInDone", busy, 0);
        @(posedge clk); #1;
        checkOutput("t1DonePulse", done, 0);

        $display("[TB] error mix");
        pulseStart();
        applyStimulus(16'h1000, 16'h0000, 17'h00FFF, 1'b1);
        applyStimulus(16'h1000, 16'h0000, 17'h01000, 1'b1);
        applyStimulus(16'h1000, 16'h0000, 17'h00801, 1'b1);
        applyStimulus(16'h1000, 16'h0000, 17'h00FFD, 1'b1);
        waitDone(edges);
        checkOutput("t2DoneLat", edges, 2);
        checkOutput("t2Err", errCnt, 3);
        checkOutput("t2Sed", sed, 32'h803);
        checkOutput("t2Max", maxEd, 32'h7FF);
        checkOutput("t2Sample", sampleCnt, 4);

        $display("[TB] start in done cycle");
        pulseStart();
        checkOutput("t7Busy", busy, 1);
        checkOutput("t7Done", done, 0);
        checkOutput("t7Err", errCnt, 0);
        checkOutput("t7Sed", sed, 0);
        checkOutput("t7Max", maxEd, 0);
        checkOutput("t7Sample", sampleCnt, 0);

        $display("[TB] saturation");
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'h0000, 17'h1FFFF, 1'b1);
        waitDone(edges);
        checkOutput("t3DoneLat", edges, 2);
        checkOutput("t3Sed", sed, 32'h3FFFF);
        checkOutput("t3Max", maxEd, 32'h1FFFF);
        checkOutput("t3Err", errCnt, 4);

        $display("[TB] gapped, start in RUN, overflow samples");
        pulseStart();
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b1);
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b0);
        pulseStart();
        checkOutput("t4BusyAfterStart", busy, 1);
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b1);
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b0);
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b1);
        applyStimulus(16'h0100, 16'h0011, 17'h00116, 1'b1);
        applyStimulus(16'h0100, 16'h0011, 17'h00011, 1'b1);
        waitDone(edges);
        checkOutput("t4DoneLat", edges, 1);
        applyStimulus(16'h0100, 16'h0011, 17'h00011, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t4Err", errCnt, 4);
        checkOutput("t4Sed", sed, 32'h14);
        checkOutput("t4Max", maxEd, 5);
        checkOutput("t4Sample", sampleCnt, 4);
        checkOutput("t4Busy", busy, 0);

        $display("[TB] reset mid-window");
        pulseStart();
        applyStimulus(16'h0010, 16'h0000, 17'h0000F, 1'b1);
        applyStimulus(16'h0010, 16'h0000, 17'h0000E, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t5PreSample", sampleCnt, 2);
        checkOutput("t5PreSed", sed, 3);
        rst = 1'b1;
        #1;
        checkOutput("t5Busy", busy, 0);
        checkOutput("t5Sample", sampleCnt, 0);
        checkOutput("t5Sed", sed, 0);
        checkOutput("t5Err", errCnt, 0);
        checkOutput("t5Max", maxEd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        doneSeen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        checkOutput("t5NoDone", doneSeen, 0);
        checkOutput("t5Idle", busy, 0);

        $display("[TB] fresh window after reset");
        pulseStart();
        for (int i = 0; i < 4; i++) applyStimulus(16'h1234, 16'h0F0F, 17'h02143, 1'b1);
        waitDone(edges);
        checkOutput("t6DoneLat", edges, 2);
        checkOutput("t6Err", errCnt, 0);
        checkOutput("t6Sed", sed, 0);
        checkOutput("t6Sample", sampleCnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
